branch_predictor: RTL and testbench

Dynamic branch predictor and redirect controller for the 5-stage RV32I pipeline. Holds a direct-mapped branch target buffer with 2-bit saturating counters. In IF it predicts taken/not-taken and a target for the fetch PC. When a conditional branch resolves in EX, it compares the actual outcome with the prediction carried down the pipe, raises redirect/flush on a mispredict, and trains the table.

---
 rtl/branch_predictor.sv | 99 +++++++++
 tb/tb_branch_predictor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch-stage prediction,
// EX-stage mispredict detection with redirect/flush, table training and branch statistics.
module branch_predictor #(
  parameter int          ENTRIES   = 16,
  parameter logic [1:0]  RESET_CTR = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_stall,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = 30 - IDX;

  logic          valid_q  [ENTRIES];
  logic [TW-1:0] tag_q    [ENTRIES];
  logic [31:0]   target_q [ENTRIES];
  logic [1:0]    ctr_q    [ENTRIES];

  logic [IDX-1:0] if_idx, ex_idx;
  logic [TW-1:0]  if_tag, ex_tag;
  logic           if_hit, ex_hit;
  logic           train;
  logic           mispredict;
  logic           unused_pc_bits;

  assign if_idx = if_pc[IDX+1:2];
  assign if_tag = if_pc[31:IDX+2];
  assign ex_idx = ex_pc[IDX+1:2];
  assign ex_tag = ex_pc[31:IDX+2];
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // Lookup reads registered state only; a same-cycle training write is not bypassed.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);

  // A branch resolves only when EX is both valid and not stalled.
  assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign train      = ex_valid && !ex_stall;
  assign mispredict = train && ((ex_taken != ex_pred_taken) ||
                                (ex_taken && (ex_target != ex_pred_target)));

  assign redirect    = mispredict;
  assign flush       = mispredict;
  assign redirect_pc = mispredict ? (ex_taken ? ex_target : (ex_pc + 32'd4)) : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= RESET_CTR;
      end
    end else if (train) begin
      if (ex_taken) begin
        if (ex_hit) begin
          if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
          target_q[ex_idx] <= ex_target;
        end else begin
          // Allocation evicts whatever alias occupied this slot.
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          target_q[ex_idx] <= ex_target;
          ctr_q[ex_idx]    <= 2'b10;
        end
      end else if (ex_hit && (ctr_q[ex_idx] != 2'b00)) begin
        ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else if (train) begin
      if (branch_count != 32'hFFFF_FFFF) branch_count <= branch_count + 32'd1;
      if (mispredict && (mispredict_count != 32'hFFFF_FFFF))
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: behavioural BTB model feeds an expected-output queue that is
// compared each cycle, plus directed checks of the documented scenarios and a random phase.
module tb_branch_predictor;

  localparam int W = 131;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_stall, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        redirect, flush;
  logic [31:0] redirect_pc, branch_count, mispredict_count;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16), .RESET_CTR(2'b01)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // Reference table: index pc[5:2], tag pc[31:6] for 16 entries.
  logic        m_valid  [16];
  logic [25:0] m_tag    [16];
  logic [31:0] m_target [16];
  logic [1:0]  m_ctr    [16];
  logic [31:0] m_bc, m_mc;

  logic        obs_pt, obs_redirect;
  logic [31:0] obs_ptg, obs_rpc, obs_bc, obs_mc;

  logic [31:0] pc_pool  [8] = '{32'h100, 32'h140, 32'h180, 32'h104, 32'h1C0, 32'h108, 32'h148, 32'hFFFFFFFC};
  logic [31:0] tgt_pool [4] = '{32'h80, 32'h90, 32'h200, 32'h300};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_target[i] = '0; m_ctr[i] = 2'b01;
    end
    m_bc = 0; m_mc = 0;
  endtask

  function automatic logic model_mis();
    return ex_valid && !ex_stall &&
           ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target));
  endfunction

  function automatic logic [W-1:0] model_expect();
    logic [3:0]  i;
    logic        pt, mis;
    logic [31:0] ptg, rpc;
    i   = if_pc[5:2];
    pt  = m_valid[i] && (m_tag[i] == if_pc[31:6]) && m_ctr[i][1];
    ptg = pt ? m_target[i] : if_pc + 32'd4;
    mis = model_mis();
    rpc = !mis ? 32'd0 : (ex_taken ? ex_target : ex_pc + 32'd4);
    return {pt, ptg, mis, rpc, mis, m_bc, m_mc};
  endfunction

  task automatic model_train();
    logic [3:0] i;
    logic       hit;
    if (!(ex_valid && !ex_stall)) return;
    i   = ex_pc[5:2];
    hit = m_valid[i] && (m_tag[i] == ex_pc[31:6]);
    if (model_mis() && m_mc != 32'hFFFFFFFF) m_mc = m_mc + 1;
    if (m_bc != 32'hFFFFFFFF) m_bc = m_bc + 1;
    if (ex_taken && hit) begin
      if (m_ctr[i] < 2'b11) m_ctr[i] = m_ctr[i] + 1;
      m_target[i] = ex_target;
    end else if (ex_taken) begin
      m_valid[i] = 1'b1; m_tag[i] = ex_pc[31:6]; m_target[i] = ex_target; m_ctr[i] = 2'b10;
    end else if (hit && m_ctr[i] > 2'b00) begin
      m_ctr[i] = m_ctr[i] - 1;
    end
  endtask

  task automatic compare_outputs();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    obs_pt = pred_taken; obs_ptg = pred_target; obs_redirect = redirect;
    obs_rpc = redirect_pc; obs_bc = branch_count; obs_mc = mispredict_count;
    check("pred_taken",  {31'd0, pred_taken}, {31'd0, e[130]});
    check("pred_target", pred_target,         e[129:98]);
    check("redirect",    {31'd0, redirect},   {31'd0, e[97]});
    check("redirect_pc", redirect_pc,         e[96:65]);
    check("flush",       {31'd0, flush},      {31'd0, e[64]});
    check("branch_cnt",  branch_count,        e[63:32]);
    check("mispred_cnt", mispredict_count,    e[31:0]);
  endtask

  // One pipeline cycle: drive, push expected, sample at negedge, then advance the model at posedge.
  task automatic step(input logic [31:0] ipc, input logic v, input logic s, input logic [31:0] epc,
                      input logic t, input logic [31:0] tgt, input logic pt, input logic [31:0] ptg);
    if_pc = ipc; ex_valid = v; ex_stall = s; ex_pc = epc;
    ex_taken = t; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
    exp_q.push_back(model_expect());
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    model_train();
    #1;
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(ipc, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++) begin
      step(pc_pool[$urandom_range(0, 7)], ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
           pc_pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), tgt_pool[$urandom_range(0, 3)],
           1'($urandom_range(0, 1)), tgt_pool[$urandom_range(0, 3)]);
    end
  endtask

  initial begin
    reset = 1'b1; if_pc = 32'h100; ex_valid = 0; ex_stall = 0; ex_pc = 0;
    ex_taken = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    model_reset();
    #3;
    check("rst_pred_taken",  {31'd0, pred_taken}, 32'd0);
    check("rst_pred_target", pred_target, 32'h104);
    check("rst_redirect",    {31'd0, redirect}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_counts",      branch_count | mispredict_count, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Cold taken branch: redirect now, prediction visible next cycle only.
    step(32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 32'h0);
    check("cold_redirect",    {31'd0, obs_redirect}, 32'd1);
    check("cold_redirect_pc", obs_rpc, 32'h80);
    check("cold_no_bypass",   {31'd0, obs_pt}, 32'd0);
    idle(32'h100);
    check("cold_pred_taken",  {31'd0, obs_pt}, 32'd1);
    check("cold_pred_target", obs_ptg, 32'h80);
    check("cold_counts",      {obs_bc[15:0], obs_mc[15:0]}, 32'h0001_0001);

    // Hysteresis: 10 -> 01 (not taken), 01 -> 10 -> 11 -> 11, then 11 -> 10 still taken.
    step(32'h100, 1, 0, 32'h100, 0, 32'h80, 1, 32'h80);
    check("hyst_redirect_pc", obs_rpc, 32'h104);
    idle(32'h100);
    check("hyst_weak_nt", {31'd0, obs_pt}, 32'd0);
    step(32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 32'h0);
    idle(32'h100);
    check("hyst_restored", {31'd0, obs_pt}, 32'd1);
    step(32'h100, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80);
    check("hyst_no_redirect", {31'd0, obs_redirect}, 32'd0);
    step(32'h100, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80);
    step(32'h100, 1, 0, 32'h100, 0, 32'h80, 1, 32'h80);
    idle(32'h100);
    check("hyst_saturated", {31'd0, obs_pt}, 32'd1);

    // Target mismatch on a hit.
    step(32'h100, 1, 0, 32'h100, 1, 32'h90, 1, 32'h80);
    check("tgt_redirect_pc", obs_rpc, 32'h90);
    idle(32'h100);
    check("tgt_updated", obs_ptg, 32'h90);

    // Alias eviction: 0x140 shares index 0 with 0x100.
    step(32'h100, 1, 0, 32'h140, 1, 32'h200, 0, 32'h0);
    idle(32'h100);
    check("alias_evicted", {31'd0, obs_pt}, 32'd0);
    check("alias_fallthru", obs_ptg, 32'h104);
    idle(32'h140);
    check("alias_new_tgt", obs_ptg, 32'h200);

    // Stalled mispredict: no redirect, no training, no statistics.
    step(32'h140, 1, 1, 32'h140, 0, 32'h0, 1, 32'h200);
    check("stall_redirect", {31'd0, obs_redirect}, 32'd0);
    idle(32'h140);
    check("stall_frozen", {31'd0, obs_pt}, 32'd1);

    // Wrap-around of pc+4.
    step(32'hFFFFFFFC, 1, 0, 32'hFFFFFFFC, 0, 32'h0, 1, 32'h80);
    check("wrap_pred_target", obs_ptg, 32'h0);
    check("wrap_redirect_pc", obs_rpc, 32'h0);

    random_phase(300);

    // Asynchronous reset mid-run, sampled well away from any clock edge.
    idle(32'h140);
    step(32'h140, 1, 0, 32'h140, 1, 32'h300, 0, 32'h0);
    ex_valid = 1'b0; if_pc = 32'h140;
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("midrst_pred_taken", {31'd0, pred_taken}, 32'd0);
    check("midrst_pred_tgt",   pred_target, 32'h144);
    check("midrst_bcount",     branch_count, 32'd0);
    check("midrst_mcount",     mispredict_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    random_phase(100);

    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
